// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Harvard-to-single-bus bridge.
package mips_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IFETCH,
    S_IWAIT,
    S_DWAIT,
    S_STEP
  } state_t;

  localparam logic [3:0] BUS_BE_ALL = 4'b1111;

  localparam int unsigned ERR_RDWR     = 0;
  localparam int unsigned ERR_MISALIGN = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_bus_wait_timer.sv
// Counts consecutive stalled bus cycles; pulses timeout on the TIMEOUT-th one.
module mips_bus_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic stall,
  output logic timeout
);

  localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign timeout = (TIMEOUT != 0) && active && stall && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (!active)
      count_d = '0;
    else if (stall && !timeout && (TIMEOUT != 0))
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/mips_harvard_bus_bridge.sv
// Serialises mips_cpu_harvard instruction/data ports onto one Avalon-MM bus,
// stepping the CPU through cpu_clk_enable once per completed access set.
module mips_harvard_bus_bridge
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          ICACHE_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  output logic        cpu_clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic [2:0]  err_flags
);

  state_t      state_q, state_d;
  logic        bus_read_q, bus_read_d;
  logic        bus_write_q, bus_write_d;
  logic [31:0] bus_address_q, bus_address_d;
  logic [31:0] bus_writedata_q, bus_writedata_d;
  logic [31:0] instr_rd_q, instr_rd_d;
  logic [31:0] data_rd_q, data_rd_d;
  logic [31:0] last_addr_q, last_addr_d;
  logic        last_valid_q, last_valid_d;
  logic [2:0]  err_q, err_d;

  logic wait_active, wait_timeout, wait_done, go_data;

  assign wait_active = (state_q == S_IWAIT) || (state_q == S_DWAIT);
  assign wait_done   = wait_active && (!bus_waitrequest || wait_timeout);

  mips_bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (wait_active),
    .stall   (bus_waitrequest),
    .timeout (wait_timeout)
  );

  always_comb begin
    state_d         = state_q;
    bus_read_d      = bus_read_q;
    bus_write_d     = bus_write_q;
    bus_address_d   = bus_address_q;
    bus_writedata_d = bus_writedata_q;
    instr_rd_d      = instr_rd_q;
    data_rd_d       = data_rd_q;
    last_addr_d     = last_addr_q;
    last_valid_d    = last_valid_q;
    err_d           = err_q;
    go_data         = 1'b0;

    case (state_q)
      S_IDLE: if (cpu_active) state_d = S_IFETCH;
      S_IFETCH: begin
        if (ICACHE_LAST && last_valid_q && (instr_address == last_addr_q)) begin
          go_data = 1'b1;
        end else begin
          bus_read_d    = 1'b1;
          bus_address_d = word_align(instr_address);
          state_d       = S_IWAIT;
        end
      end
      S_IWAIT: begin
        if (wait_done) begin
          bus_read_d = 1'b0;
          go_data    = 1'b1;
          if (wait_timeout) begin
            instr_rd_d         = '0;
            err_d[ERR_TIMEOUT] = 1'b1;
          end else begin
            instr_rd_d   = bus_readdata;
            last_addr_d  = bus_address_q;
            last_valid_d = 1'b1;
          end
        end
      end
      S_DWAIT: begin
        if (wait_done) begin
          bus_read_d  = 1'b0;
          bus_write_d = 1'b0;
          state_d     = S_STEP;
          if (bus_read_q)
            data_rd_d = wait_timeout ? '0 : bus_readdata;
          if (bus_write_q && (bus_address_q == last_addr_q))
            last_valid_d = 1'b0;
          if (wait_timeout)
            err_d[ERR_TIMEOUT] = 1'b1;
        end
      end
      S_STEP:  state_d = cpu_active ? S_IFETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The data-access decision is taken on the fetch-completion edge rather
    // than in a state of its own, so a bare step costs 3 cycles and a hit 2.
    if (go_data) begin
      if (data_write || data_read) begin
        bus_write_d     = data_write;
        bus_read_d      = !data_write;
        bus_address_d   = word_align(data_address);
        bus_writedata_d = data_writedata;
        state_d         = S_DWAIT;
        if (data_write && data_read)    err_d[ERR_RDWR]     = 1'b1;
        if (data_address[1:0] != 2'b00) err_d[ERR_MISALIGN] = 1'b1;
      end else begin
        state_d = S_STEP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      bus_read_q      <= 1'b0;
      bus_write_q     <= 1'b0;
      bus_address_q   <= '0;
      bus_writedata_q <= '0;
      instr_rd_q      <= '0;
      data_rd_q       <= '0;
      last_addr_q     <= '0;
      last_valid_q    <= 1'b0;
      err_q           <= '0;
    end else begin
      state_q         <= state_d;
      bus_read_q      <= bus_read_d;
      bus_write_q     <= bus_write_d;
      bus_address_q   <= bus_address_d;
      bus_writedata_q <= bus_writedata_d;
      instr_rd_q      <= instr_rd_d;
      data_rd_q       <= data_rd_d;
      last_addr_q     <= last_addr_d;
      last_valid_q    <= last_valid_d;
      err_q           <= err_d;
    end
  end

  assign cpu_clk_enable = (state_q == S_STEP);
  assign instr_readdata = instr_rd_q;
  assign data_readdata  = data_rd_q;
  assign bus_address    = bus_address_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign bus_byteenable = BUS_BE_ALL;
  assign bus_writedata  = bus_writedata_q;
  assign err_flags      = err_q;

endmodule

// File: tb/tb_mips_harvard_bus_bridge.sv
// Directed bench for mips_harvard_bus_bridge: fetch, stalls, cache hit, load,
// store-invalidate, timeout, error flags and reset mid-access.
module tb_mips_harvard_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_active;
  logic        cpu_clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic [2:0]  err_flags;

  int total = 0;
  int bad   = 0;
  logic viol = 1'b0;

  always #5 clk = ~clk;

  mips_harvard_bus_bridge #(.TIMEOUT(16), .ICACHE_LAST(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_active      (cpu_active),
    .cpu_clk_enable  (cpu_clk_enable),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .data_address    (data_address),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_writedata  (data_writedata),
    .data_readdata   (data_readdata),
    .bus_address     (bus_address),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_byteenable  (bus_byteenable),
    .bus_writedata   (bus_writedata),
    .bus_waitrequest (bus_waitrequest),
    .bus_readdata    (bus_readdata),
    .err_flags       (err_flags)
  );

  function automatic logic [31:0] fake_mem(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h24020005;
      32'hBFC00004: return 32'h24030007;
      32'hBFC00008: return 32'h8C440000;
      32'h00001000: return 32'hCAFEF00D;
      default:      return a ^ 32'h5A5A5A5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until the step pulse (bounded), acting as the bus slave; stall_n
  // cycles of waitrequest are inserted on visible strobes.
  task automatic run_step(input int stall_n, input int max_cyc,
                          output int cyc, output int rd, output int wr,
                          output logic [31:0] rd_addr, output logic [31:0] wr_addr,
                          output logic [31:0] wdata, output logic [3:0] be);
    int stall_left = stall_n;
    cyc = 0; rd = 0; wr = 0;
    rd_addr = '0; wr_addr = '0; wdata = '0; be = '0;
    bus_waitrequest = 1'b0;
    bus_readdata    = fake_mem(bus_address);
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      cyc++;
      if (bus_read && bus_write) viol = 1'b1;
      if (cpu_clk_enable && (bus_read || bus_write)) viol = 1'b1;
      if (bus_read)  begin rd++; rd_addr = bus_address; end
      if (bus_write) begin wr++; wr_addr = bus_address; wdata = bus_writedata; be = bus_byteenable; end
      if (cpu_clk_enable) return;
      bus_readdata = fake_mem(bus_address);
      if ((bus_read || bus_write) && stall_left > 0) begin
        bus_waitrequest = 1'b1;
        stall_left--;
      end else begin
        bus_waitrequest = 1'b0;
      end
    end
    cyc = -1;
  endtask

  initial begin
    int cyc, rd, wr;
    logic [31:0] ra, wa, wd;
    logic [3:0]  be;

    reset = 1'b1; cpu_active = 1'b0;
    instr_address = 32'hBFC00000; data_address = '0;
    data_read = 1'b0; data_write = 1'b0; data_writedata = '0;
    bus_waitrequest = 1'b0; bus_readdata = '0;
    tick(); tick();

    check("rst_read",   {31'd0, bus_read},       32'd0);
    check("rst_write",  {31'd0, bus_write},      32'd0);
    check("rst_addr",   bus_address,             32'd0);
    check("rst_step",   {31'd0, cpu_clk_enable}, 32'd0);
    check("rst_instr",  instr_readdata,          32'd0);
    check("rst_data",   data_readdata,           32'd0);
    check("rst_err",    {29'd0, err_flags},      32'd0);
    check("byteenable", {28'd0, bus_byteenable}, 32'hF);

    // 1: first fetch from reset
    cpu_active = 1'b1; reset = 1'b0;
    run_step(0, 50, cyc, rd, wr, ra, wa, wd, be);
    check("t1_cycles", 32'(cyc), 32'd3);
    check("t1_reads",  32'(rd), 32'd1);
    check("t1_addr",   ra, 32'hBFC00000);
    check("t1_instr",  instr_readdata, 32'h24020005);

    // 2: fetch stalled 5 cycles
    instr_address = 32'hBFC00004;
    run_step(5, 50, cyc, rd, wr, ra, wa, wd, be);
    check("t2_cycles", 32'(cyc), 32'd8);
    check("t2_reads",  32'(rd), 32'd6);
    check("t2_instr",  instr_readdata, 32'h24030007);
    check("t2_err",    {29'd0, err_flags}, 32'd0);

    // same address again: cache hit, no bus cycle
    run_step(0, 50, cyc, rd, wr, ra, wa, wd, be);
    check("hit_cycles", 32'(cyc), 32'd2);
    check("hit_reads",  32'(rd), 32'd0);

    // 3: fetch plus data load
    instr_address = 32'hBFC00008;
    data_read = 1'b1; data_address = 32'h00001000;
    run_step(0, 50, cyc, rd, wr, ra, wa, wd, be);
    check("t3_cycles", 32'(cyc), 32'd4);
    check("t3_reads",  32'(rd), 32'd2);
    check("t3_addr",   ra, 32'h00001000);
    check("t3_data",   data_readdata, 32'hCAFEF00D);
    check("t3_instr",  instr_readdata, 32'h8C440000);

    // 4: store to last fetched address invalidates the cached fetch
    data_read = 1'b0; data_write = 1'b1;
    data_address = 32'hBFC00008; data_writedata = 32'h12345678;
    run_step(0, 50, cyc, rd, wr, ra, wa, wd, be);
    check("t4_cycles", 32'(cyc), 32'd3);
    check("t4_reads",  32'(rd), 32'd0);
    check("t4_writes", 32'(wr), 32'd1);
    check("t4_waddr",  wa, 32'hBFC00008);
    check("t4_wdata",  wd, 32'h12345678);
    check("t4_be",     {28'd0, be}, 32'hF);
    data_write = 1'b0;
    run_step(0, 50, cyc, rd, wr, ra, wa, wd, be);
    check("t4_refetch_cycles", 32'(cyc), 32'd3);
    check("t4_refetch_reads",  32'(rd), 32'd1);
    check("t4_refetch_addr",   ra, 32'hBFC00008);

    // 5: waitrequest stuck high -> timeout after 16 stalled cycles
    instr_address = 32'hBFC0000C;
    run_step(1000, 100, cyc, rd, wr, ra, wa, wd, be);
    check("t5_cycles", 32'(cyc), 32'd18);
    check("t5_reads",  32'(rd), 32'd16);
    check("t5_err",    {29'd0, err_flags}, 32'h4);
    check("t5_instr",  instr_readdata, 32'd0);

    check("no_rd_wr_overlap", {31'd0, viol}, 32'd0);

    // 6: read+write with misaligned address, from a fresh reset
    reset = 1'b1; bus_waitrequest = 1'b0;
    instr_address = 32'hBFC00000;
    tick(); tick();
    check("t6_rst_err", {29'd0, err_flags}, 32'd0);
    reset = 1'b0;
    data_read = 1'b1; data_write = 1'b1;
    data_address = 32'h00001002; data_writedata = 32'hDEADBEEF;
    run_step(0, 50, cyc, rd, wr, ra, wa, wd, be);
    check("t6_cycles", 32'(cyc), 32'd4);
    check("t6_reads",  32'(rd), 32'd1);
    check("t6_writes", 32'(wr), 32'd1);
    check("t6_waddr",  wa, 32'h00001000);
    check("t6_wdata",  wd, 32'hDEADBEEF);
    check("t6_err",    {29'd0, err_flags}, 32'h3);

    // next step hits the cache and stalls in the write; reset abandons it
    bus_waitrequest = 1'b1;
    tick();
    check("t6_hit_no_read", {31'd0, bus_read}, 32'd0);
    tick();
    check("t6_write_up", {31'd0, bus_write}, 32'd1);
    tick();
    check("t6_write_held", {31'd0, bus_write}, 32'd1);
    reset = 1'b1;
    tick();
    check("t6_rst_write", {31'd0, bus_write},      32'd0);
    check("t6_rst_read",  {31'd0, bus_read},       32'd0);
    check("t6_rst_flags", {29'd0, err_flags},      32'd0);
    check("t6_rst_step",  {31'd0, cpu_clk_enable}, 32'd0);
    check("t6_rst_addr",  bus_address,             32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
